// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: validates one execute-stage request, drives a single
// memory access cycle, captures load data and holds the response for the pipeline.
module lsu_mem_initiator #(
    parameter int unsigned MEM_BYTES = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_dw,
    input  logic        req_sign_ex,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic        mem_en,
    output logic        mem_l,
    output logic        mem_s,
    output logic [1:0]  mem_dw,
    output logic        mem_sign_ex,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] cnt_loads,
    output logic [31:0] cnt_stores,
    output logic [31:0] cnt_errors
);

    // data_width encoding shared with the data memory
    localparam logic [1:0] DB = 2'd0;
    localparam logic [1:0] DH = 2'd1;
    localparam logic [1:0] DW = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic        op_load_q, op_load_d;
    logic [1:0]  op_dw_q, op_dw_d;
    logic        op_sign_ex_q, op_sign_ex_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  resp_cause_q, resp_cause_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_l_q, mem_l_d;
    logic        mem_s_q, mem_s_d;
    logic [1:0]  mem_dw_q, mem_dw_d;
    logic        mem_sign_ex_q, mem_sign_ex_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] cnt_loads_q, cnt_loads_d;
    logic [31:0] cnt_stores_q, cnt_stores_d;
    logic [31:0] cnt_errors_q, cnt_errors_d;

    logic        is_illegal, is_misaligned, is_out_of_range;
    logic [32:0] req_bytes, req_end;

    // The end address is formed in 33 bits so a request wrapping past 2^32 is out of range.
    always_comb begin
        unique case (req_dw)
            DB:      req_bytes = 33'd1;
            DH:      req_bytes = 33'd2;
            default: req_bytes = 33'd4;
        endcase
        req_end         = {1'b0, req_addr} + req_bytes;
        is_illegal      = (req_load == req_store) || (req_dw == 2'd3);
        is_misaligned   = ((req_dw == DH) && req_addr[0]) ||
                          ((req_dw == DW) && (req_addr[1:0] != 2'b00));
        is_out_of_range = req_end > 33'(MEM_BYTES);
    end

    always_comb begin
        // NOTE: every _d takes its held value first so no path through the case infers a latch.
        state_d      = state_q;
        op_load_d    = op_load_q;
        op_dw_d      = op_dw_q;
        op_sign_ex_d = op_sign_ex_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        resp_cause_d = resp_cause_q;
        cnt_loads_d  = cnt_loads_q;
        cnt_stores_d = cnt_stores_q;
        cnt_errors_d = cnt_errors_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_load_d    = req_load;
                    op_dw_d      = req_dw;
                    op_sign_ex_d = req_sign_ex;
                    op_addr_d    = req_addr;
                    op_wdata_d   = req_wdata;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                    if (is_illegal)           resp_cause_d = CAUSE_ILLEGAL;
                    else if (is_misaligned)   resp_cause_d = CAUSE_MISALIGN;
                    else if (is_out_of_range) resp_cause_d = CAUSE_RANGE;
                    else begin
                        resp_err_d   = 1'b0;
                        resp_cause_d = CAUSE_NONE;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE:   state_d = op_load_q ? CAPTURE : RESP;
            CAPTURE: begin
                resp_rdata_d = mem_rdata;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (resp_err_q)     cnt_errors_d = cnt_errors_q + 32'd1;
                    else if (op_load_q) cnt_loads_d  = cnt_loads_q + 32'd1;
                    else                cnt_stores_d = cnt_stores_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_ready_d   = (state_d == IDLE);
        resp_valid_d  = (state_d == RESP);
        mem_en_d      = (state_d == ISSUE);
        mem_l_d       = mem_en_d && op_load_d;
        mem_s_d       = mem_en_d && !op_load_d;
        mem_dw_d      = mem_en_d ? op_dw_d      : 2'd0;
        mem_sign_ex_d = mem_en_d && op_sign_ex_d;
        mem_addr_d    = mem_en_d ? op_addr_d    : 32'd0;
        mem_wdata_d   = mem_en_d ? op_wdata_d   : 32'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_load_q     <= 1'b0;
            op_dw_q       <= 2'd0;
            op_sign_ex_q  <= 1'b0;
            op_addr_q     <= '0;
            op_wdata_q    <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            resp_cause_q  <= CAUSE_NONE;
            mem_en_q      <= 1'b0;
            mem_l_q       <= 1'b0;
            mem_s_q       <= 1'b0;
            mem_dw_q      <= 2'd0;
            mem_sign_ex_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cnt_loads_q   <= '0;
            cnt_stores_q  <= '0;
            cnt_errors_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_load_q     <= op_load_d;
            op_dw_q       <= op_dw_d;
            op_sign_ex_q  <= op_sign_ex_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            resp_cause_q  <= resp_cause_d;
            mem_en_q      <= mem_en_d;
            mem_l_q       <= mem_l_d;
            mem_s_q       <= mem_s_d;
            mem_dw_q      <= mem_dw_d;
            mem_sign_ex_q <= mem_sign_ex_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cnt_loads_q   <= cnt_loads_d;
            cnt_stores_q  <= cnt_stores_d;
            cnt_errors_q  <= cnt_errors_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign resp_cause  = resp_cause_q;
    assign mem_en      = mem_en_q;
    assign mem_l       = mem_l_q;
    assign mem_s       = mem_s_q;
    assign mem_dw      = mem_dw_q;
    assign mem_sign_ex = mem_sign_ex_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cnt_loads   = cnt_loads_q;
    assign cnt_stores  = cnt_stores_q;
    assign cnt_errors  = cnt_errors_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte-addressed memory model that
// writes on the ISSUE negedge and returns load data in the following cycle.
module tb_lsu_mem_initiator;

    localparam int unsigned MEM_BYTES = 131072;
    localparam logic [1:0] DB = 2'd0, DH = 2'd1, DW = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, req_sign_ex = 1'b0;
    logic [1:0]  req_dw = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [1:0]  resp_cause, mem_dw;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_l, mem_s, mem_sign_ex;
    logic [31:0] mem_rdata = '0;
    logic [31:0] cnt_loads, cnt_stores, cnt_errors;

    int checks = 0;
    int failures = 0;

    lsu_mem_initiator #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_store(req_store), .req_dw(req_dw), .req_sign_ex(req_sign_ex),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_cause(resp_cause),
        .mem_en(mem_en), .mem_l(mem_l), .mem_s(mem_s), .mem_dw(mem_dw),
        .mem_sign_ex(mem_sign_ex), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_errors(cnt_errors)
    );

    always #5 clk = ~clk;

    // Memory model: little-endian bytes, width-masked writes, masked/extended reads.
    logic [7:0] mem_model [int unsigned];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (mem_en && mem_s) begin
            mem_model[mem_addr] = mem_wdata[7:0];
            if (mem_dw != DB) mem_model[mem_addr + 32'd1] = mem_wdata[15:8];
            if (mem_dw == DW) begin
                mem_model[mem_addr + 32'd2] = mem_wdata[23:16];
                mem_model[mem_addr + 32'd3] = mem_wdata[31:24];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_en && mem_l) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = rd_byte(mem_addr);
            b1 = rd_byte(mem_addr + 32'd1);
            b2 = rd_byte(mem_addr + 32'd2);
            b3 = rd_byte(mem_addr + 32'd3);
            case (mem_dw)
                DB:      mem_rdata <= {{24{mem_sign_ex & b0[7]}}, b0};
                DH:      mem_rdata <= {{16{mem_sign_ex & b1[7]}}, b1, b0};
                default: mem_rdata <= {b3, b2, b1, b0};
            endcase
        end else begin
            mem_rdata <= 32'hA5A5_A5A5;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; accept edge N, then expect resp at N+lat with the given fields.
    task automatic run_op(input string tag, input logic ld, input logic st, input logic [1:0] dw,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [1:0] exp_cause,
                          input logic [31:0] exp_rdata);
        int lat, en_cnt;
        logic el, es, esx;
        logic [1:0] edw;
        logic [31:0] ea, ewd;
        el = 0; es = 0; esx = 0; edw = 0; ea = 0; ewd = 0;
        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_load = ld; req_store = st; req_dw = dw;
        req_sign_ex = sx; req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_addr = 32'h5555_5555; req_wdata = 32'h6666_6666;
        lat = 1; en_cnt = 0;
        while (!resp_valid && lat < 10) begin
            if (mem_en) begin
                en_cnt++; el = mem_l; es = mem_s; edw = mem_dw; esx = mem_sign_ex;
                ea = mem_addr; ewd = mem_wdata;
            end
            step();
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".mem_en_cycles"}, en_cnt, exp_err ? 0 : 1);
        if (!exp_err) begin
            check({tag, ".mem_l"}, {31'd0, el}, {31'd0, ld});
            check({tag, ".mem_s"}, {31'd0, es}, {31'd0, st});
            check({tag, ".mem_dw"}, {30'd0, edw}, {30'd0, dw});
            check({tag, ".mem_sign_ex"}, {31'd0, esx}, {31'd0, sx});
            check({tag, ".mem_addr"}, ea, addr);
            check({tag, ".mem_wdata"}, ewd, wdata);
        end
        check({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, ".resp_cause"}, {30'd0, resp_cause}, {30'd0, exp_cause});
        check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        check({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
        check({tag, ".resp_mem_en"}, {31'd0, mem_en}, 32'd0);
        if (resp_ready) begin
            step();
            check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
            check({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
        end
    endtask

    task automatic check_cnts(input string tag, input int ld, input int st, input int er);
        check({tag, ".cnt_loads"}, cnt_loads, ld);
        check({tag, ".cnt_stores"}, cnt_stores, st);
        check({tag, ".cnt_errors"}, cnt_errors, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        check("rst.resp_cause", {30'd0, resp_cause}, 32'd0);
        check("rst.mem", {mem_en, mem_l, mem_s, mem_sign_ex, mem_dw, 26'd0}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check_cnts("rst", 0, 0, 0);
        rst = 1'b0;
        step();

        run_op("st_word", 0, 1, DW, 0, 32'h100, 32'hDEAD_BEEF, 2, 0, 2'd0, 32'd0);
        run_op("ld_word", 1, 0, DW, 0, 32'h100, 32'h0, 3, 0, 2'd0, 32'hDEAD_BEEF);
        check_cnts("word", 1, 1, 0);

        run_op("st_byte", 0, 1, DB, 0, 32'h203, 32'h1234_5680, 2, 0, 2'd0, 32'd0);
        run_op("ld_byte_s", 1, 0, DB, 1, 32'h203, 32'h0, 3, 0, 2'd0, 32'hFFFF_FF80);
        run_op("ld_byte_u", 1, 0, DB, 0, 32'h203, 32'h0, 3, 0, 2'd0, 32'h0000_0080);

        run_op("ld_mis_h", 1, 0, DH, 0, 32'h101, 32'h0, 1, 1, 2'd1, 32'd0);
        run_op("st_mis_w", 0, 1, DW, 0, 32'h102, 32'h1111_2222, 1, 1, 2'd1, 32'd0);
        check_cnts("mis", 3, 2, 2);

        run_op("st_top", 0, 1, DW, 0, MEM_BYTES - 4, 32'hCAFE_F00D, 2, 0, 2'd0, 32'd0);
        run_op("ld_top", 1, 0, DW, 0, MEM_BYTES - 4, 32'h0, 3, 0, 2'd0, 32'hCAFE_F00D);
        run_op("ld_last_b", 1, 0, DB, 0, MEM_BYTES - 1, 32'h0, 3, 0, 2'd0, 32'h0000_00CA);
        run_op("ld_oor", 1, 0, DW, 0, MEM_BYTES, 32'h0, 1, 1, 2'd2, 32'd0);
        run_op("ld_wrap", 1, 0, DW, 0, 32'hFFFF_FFFC, 32'h0, 1, 1, 2'd2, 32'd0);
        run_op("ld_mis_oor", 1, 0, DW, 0, 32'hFFFF_FFFE, 32'h0, 1, 1, 2'd1, 32'd0);

        run_op("ill_both", 1, 1, DW, 0, 32'h100, 32'h0, 1, 1, 2'd3, 32'd0);
        run_op("ill_none", 0, 0, DW, 0, 32'h100, 32'h0, 1, 1, 2'd3, 32'd0);
        run_op("ill_dw", 1, 0, 2'd3, 0, 32'h100, 32'h0, 1, 1, 2'd3, 32'd0);
        run_op("ill_mis", 1, 1, DH, 0, 32'h101, 32'h0, 1, 1, 2'd3, 32'd0);
        check_cnts("mid", 5, 3, 9);

        // Backpressure: response held five cycles while a stray request is ignored.
        resp_ready = 1'b0;
        run_op("bp_ld", 1, 0, DW, 0, 32'h100, 32'h0, 3, 0, 2'd0, 32'hDEAD_BEEF);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_dw = DW; req_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp.resp_rdata", resp_rdata, 32'hDEAD_BEEF);
            check("bp.req_ready", {31'd0, req_ready}, 32'd0);
            check("bp.mem_en", {31'd0, mem_en}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        check("bp.release_ready", {31'd0, req_ready}, 32'd1);
        check("bp.release_valid", {31'd0, resp_valid}, 32'd0);
        check_cnts("bp", 6, 3, 9);

        // Reset asserted while the load sits in CAPTURE.
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_dw = DW; req_addr = 32'h100;
        step();
        req_valid = 1'b0;
        check("rm.issue_en", {31'd0, mem_en}, 32'd1);
        step();
        check("rm.capture_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rm.req_ready", {31'd0, req_ready}, 32'd1);
        check_cnts("rm", 0, 0, 0);
        step(); step();
        check("rm.stays_idle", {31'd0, resp_valid}, 32'd0);

        run_op("post_rst_ill", 1, 1, DB, 0, 32'h0, 32'h0, 1, 1, 2'd3, 32'd0);
        check_cnts("end", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator that turns one execute-stage memory request into the signalling expected by the byte-addressed data memory. It validates alignment and range, drives one access cycle, captures load data one cycle later, and returns a held response to the pipeline. It sits between the execute stage and the data memory's load/store port. The instruction-fetch port is not handled here.

## Interface
Parameters:
- MEM_BYTES, 131072: size of the data memory in bytes. Legal accesses satisfy `addr + size ≤ MEM_BYTES`.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_dw  in  2  access width, `data_width` encoding from defs.svh (DB, DH, DW)
- req_sign_ex  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  request was rejected; no memory access occurred
- resp_cause  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal request
- mem_en  out  1  memory access enable
- mem_l  out  1  load strobe
- mem_s  out  1  store strobe
- mem_dw  out  2  access width to memory
- mem_sign_ex  out  1  sign-extend select to memory
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  store data to memory
- mem_rdata  in  32  memory load result; valid in the cycle after the load cycle
- cnt_loads, cnt_stores, cnt_errors  out  32 each  completed-operation counters; wrap at 2^32

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - req_ready=1.
  - On `req_valid && req_ready`, register all req_* fields and classify the request.
  - Illegal (cause 3): both or neither of req_load/req_store, or req_dw not in {DB, DH, DW}.
  - Misaligned (cause 1): DH with addr[0]=1, or DW with addr[1:0]≠0.
  - Out of range (cause 2): `addr + bytes > MEM_BYTES`, computed in 33 bits so that overflow past 2^32 counts as out of range.
  - Priority: illegal > misaligned > range.
  - Error: go to RESP with resp_err=1 and the cause; no mem_en pulse.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - mem_en=1, mem_l or mem_s, mem_dw, mem_sign_ex, mem_addr, mem_wdata driven from the request register.
  - Load: go to CAPTURE.
  - Store: go to RESP; the memory commits the write on the negedge inside ISSUE.
- **CAPTURE**
  - mem_en=0.
  - resp_rdata <= mem_rdata, taken unmodified because the memory already applies masking and sign extension.
  - Go to RESP.
- **RESP**
  - resp_valid=1. resp_rdata, resp_err and resp_cause are held stable until `resp_valid && resp_ready`.
  - On that handshake, increment exactly one counter (errors take precedence) and go to IDLE.
- mem_* outputs are 0 in every state except ISSUE.
- mem_wdata is passed unmasked; the memory applies the width mask.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=0, all mem_*=0, all counters 0.
- Request accepted at posedge N:
  - Load: ISSUE in cycle N+1, CAPTURE in N+2, resp_valid high from N+3.
  - Store: ISSUE in N+1, resp_valid high from N+2.
  - Error: resp_valid high from N+1.
- No back-to-back acceptance. req_ready=0 from the cycle after acceptance until the cycle after the response handshake.
- resp_ready held high gives the minimum spacing between accepts: 4 cycles for loads, 3 for stores, 2 for errors.
- Backpressure: resp_ready=0 holds RESP indefinitely, with outputs unchanged and no further memory activity.
- req_valid in non-IDLE states is ignored. Request fields are sampled only at acceptance.
- rst high in any state: IDLE and all reset values on the next posedge.
  - A pending response is dropped and counters are cleared.
  - If rst is asserted during ISSUE, the in-flight store may already have been committed on that negedge. This is permitted.
- Counter wrap: 0xFFFFFFFF + 1 → 0.

## Test plan
- **Aligned word store/load.**
  - Store DW 0xDEADBEEF to 0x100: exactly one ISSUE cycle with mem_s=1, mem_addr=0x100, mem_dw=DW, mem_wdata=0xDEADBEEF.
  - Load DW from 0x100: resp_rdata=0xDEADBEEF at N+3; cnt_stores=1, cnt_loads=1.
- **Signed/unsigned byte loads.** With memory byte 0x80 at 0x203:
  - DB load, sign_ex=1 → 0xFFFFFF80.
  - DB load, sign_ex=0 → 0x00000080.
- **Misaligned requests.**
  - DH load at 0x101 → resp_err=1, cause=1, mem_en never asserted, resp at N+1.
  - DW store at 0x102 → same response; cnt_errors=2.
- **Range boundary.**
  - DW load at MEM_BYTES-4 → legal.
  - DW load at MEM_BYTES → cause 2.
  - DW load at 0xFFFFFFFC → cause 2, with no address wrap.
- **Backpressure.** Load completes with resp_ready=0 for 5 cycles: resp_valid and resp_rdata stay stable, req_ready=0, mem_en=0; after resp_ready=1, return to IDLE next cycle.
- **Reset mid-op and illegal request.**
  - Assert rst during CAPTURE: next cycle resp_valid=0, req_ready=1, counters=0.
  - Request with req_load=req_store=1 → cause 3.
